linear32_ctrl: RTL and testbench

LINEAR32_CTRL -- requirements
Module: linear32_ctrl

---
 rtl/linear32_ctrl_pkg.sv | 19 +
 rtl/linear32.sv | 17 +
 rtl/linear32_ctrl.sv | 106 ++++++++++
 tb/tb_linear32_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear32_ctrl_pkg.sv
// Shared definitions for the linear32 controller slice.
//   ROWS / WORD_W : matrix geometry (32 rows of 32-bit words)
//   MAT_W         : flattened matrix width, row k at bits [32*k+31 : 32*k]
//   IDX_W         : row index width
//   state_e       : controller FSM states
package linear32_ctrl_pkg;

    localparam int unsigned ROWS   = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned MAT_W  = ROWS * WORD_W;
    localparam int unsigned IDX_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StRun
    } state_e;

endpackage

// File: rtl/linear32.sv
// GF(2) matrix-vector product y = M * a.
//   a : input vector
//   m : flattened matrix, row i at bits [32*i+31 : 32*i]
//   y : result, bit i = XOR-reduction of (a AND row i)
module linear32
    import linear32_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [MAT_W-1:0]  m,
    output logic [WORD_W-1:0] y
);

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign y[i] = ^(a & m[i*WORD_W +: WORD_W]);
    end

endmodule

// File: rtl/linear32_ctrl.sv
// Controller around linear32: loads a 32x32 GF(2) matrix row by row, then
// streams input vectors through the product with a one-deep registered
// output stage (valid/ready on both sides, full throughput).
//   clk, rst             : clock, synchronous active-high reset
//   cfg_start            : begin a new matrix load
//   cfg_valid, cfg_data  : one matrix row per accepted cycle, row 0 first
//   in_valid/in_ready    : input vector handshake, in_data = vector a
//   out_valid/out_ready  : output handshake, out_data = registered result
//   loaded               : matrix complete, block in RUN
//   load_cnt             : rows written in the current load
//   vec_cnt              : vectors accepted since the last completed load
module linear32_ctrl
    import linear32_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              loaded,
    output logic [IDX_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  vec_cnt
);

    state_e             state_q;
    logic [MAT_W-1:0]   matrix_q;
    logic [WORD_W-1:0]  product;
    logic               xfer;

    assign loaded   = (state_q == StRun);
    assign in_ready = (state_q == StRun) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    linear32 u_linear32 (
        .a (in_data),
        .m (matrix_q),
        .y (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            matrix_q  <= '0;
            load_cnt  <= '0;
            vec_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (cfg_start) begin
                        state_q  <= StLoad;
                        load_cnt <= '0;
                    end
                end
                StLoad: begin
                    // A restart takes priority; the coincident row is dropped.
                    if (cfg_start) begin
                        load_cnt <= '0;
                    end else if (cfg_valid) begin
                        for (int r = 0; r < ROWS; r++) begin
                            if (load_cnt == IDX_W'(r)) begin
                                matrix_q[r*WORD_W +: WORD_W] <= cfg_data;
                            end
                        end
                        if (load_cnt == IDX_W'(ROWS - 1)) begin
                            state_q  <= StRun;
                            load_cnt <= '0;
                            vec_cnt  <= '0;
                        end else begin
                            load_cnt <= load_cnt + IDX_W'(1);
                        end
                    end
                end
                StRun: begin
                    // Reload only once the output stage is empty, so a pending
                    // result never sees its matrix replaced underneath it.
                    if (cfg_start && !out_valid) begin
                        state_q  <= StLoad;
                        load_cnt <= '0;
                    end
                end
                default: state_q <= StEmpty;
            endcase

            // Output stage; transfers only happen in RUN so vec_cnt never
            // collides with the clear at load completion.
            if (xfer) begin
                out_data  <= product;
                out_valid <= 1'b1;
                vec_cnt   <= vec_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_linear32_ctrl.sv
module tb_linear32_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [31:0]   cfg_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          loaded;
    logic [4:0]    load_cnt;
    logic [CW-1:0] vec_cnt;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    linear32_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .loaded    (loaded),
        .load_cnt  (load_cnt),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = empty, 1 = loading, 2 = running.
    int            m_mode = 0;
    logic [31:0]   m_rows [32];
    int            m_rows_done = 0;
    int            m_vecs = 0;
    bit            m_ov = 1'b0;
    logic [31:0]   m_od = '0;

    // Bit i is the parity of the ones shared by a and row i.
    function automatic logic [31:0] gf2_mul(input logic [31:0] a);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = ($countones(a & m_rows[i]) % 2) == 1;
        return r;
    endfunction

    function automatic bit m_ready(input bit ordy);
        return (m_mode == 2) && (!m_ov || ordy);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode      <= 0;
            m_rows_done <= 0;
            m_vecs      <= 0;
            m_ov        <= 1'b0;
            m_od        <= '0;
            for (int i = 0; i < 32; i++) m_rows[i] <= '0;
        end else begin
            if (in_valid && m_ready(out_ready)) begin
                m_od   <= gf2_mul(in_data);
                m_ov   <= 1'b1;
                m_vecs <= (m_vecs + 1) % (1 << CW);
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
            if (m_mode == 1) begin
                if (cfg_start) begin
                    m_rows_done <= 0;
                end else if (cfg_valid) begin
                    m_rows[m_rows_done] <= cfg_data;
                    if (m_rows_done == 31) begin
                        m_mode      <= 2;
                        m_rows_done <= 0;
                        m_vecs      <= 0;
                    end else begin
                        m_rows_done <= m_rows_done + 1;
                    end
                end
            end else if (cfg_start && (m_mode == 0 || !m_ov)) begin
                m_mode      <= 1;
                m_rows_done <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready",  64'(in_ready),  64'(m_ready(out_ready)));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_data",  64'(out_data),  64'(m_od));
            chk("loaded",    64'(loaded),    64'(m_mode == 2));
            chk("load_cnt",  64'(load_cnt),  64'(m_rows_done));
            chk("vec_cnt",   64'(vec_cnt),   64'(m_vecs));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] row_of(input int kind, input int k);
        if (kind == 0) return 32'h1 << k;
        if (kind == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    task automatic put_rows(input int kind, input int n);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = row_of(kind, k);
            cyc();
        end
        cfg_valid = 1'b0;
    endtask

    // Drains the output stage first so the load request is not ignored.
    task automatic do_load(input int kind);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        put_rows(kind, 32);
    endtask

    task automatic send_one(input string name, input logic [31:0] d, input logic [31:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, " valid"}, 64'(out_valid), 64'd1);
        chk(name, 64'(out_data), 64'(exp));
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        armed = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        chk("reset loaded",   64'(loaded),   64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset vec_cnt",  64'(vec_cnt),  64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        cyc();

        // Identity matrix passes the vector through.
        do_load(0);
        @(negedge clk);
        chk("identity loaded", 64'(loaded), 64'd1);
        cyc();
        send_one("identity", 32'hA5A5_1234, 32'hA5A5_1234);

        // All-ones rows: every bit is the parity of the whole vector.
        do_load(1);
        send_one("ones odd",  32'h0000_0007, 32'hFFFF_FFFF);
        send_one("ones even", 32'h0000_0003, 32'h0000_0000);

        // Backpressure with an ignored reload request mid-stall.
        do_load(0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1357_9BDF;
        cyc();
        in_data = 32'h2468_ACE0;
        for (int k = 0; k < 5; k++) begin
            cfg_start = (k == 2);
            @(negedge clk);
            chk("stall in_ready", 64'(in_ready), 64'd0);
            chk("stall out_data", 64'(out_data), 64'h1357_9BDF);
            cyc();
        end
        cfg_start = 1'b0;
        @(negedge clk);
        chk("stall loaded", 64'(loaded), 64'd1);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pop+push valid", 64'(out_valid), 64'd1);
        chk("pop+push data",  64'(out_data),  64'h2468_ACE0);
        cyc();

        // Streaming at full rate after a fresh load.
        do_load(0);
        @(negedge clk);
        chk("fresh vec_cnt", 64'(vec_cnt), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h100 + i;
            cyc();
            @(negedge clk);
            chk("stream valid", 64'(out_valid), 64'd1);
            chk("stream data",  64'(out_data),  64'(32'h100 + i));
        end
        in_valid = 1'b0;
        chk("stream vec_cnt", 64'(vec_cnt), 64'd8);
        cyc();

        // Reset in the middle of a load.
        do_load(2);
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        put_rows(0, 10);
        @(negedge clk);
        chk("partial load_cnt", 64'(load_cnt), 64'd10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst loaded",   64'(loaded),   64'd0);
        chk("rst load_cnt", 64'(load_cnt), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        do_load(0);
        @(negedge clk);
        chk("reload loaded", 64'(loaded), 64'd1);

        // Restart at row 20, with a coincident row that must be discarded.
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        put_rows(1, 20);
        @(negedge clk);
        chk("row20 load_cnt", 64'(load_cnt), 64'd20);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 32'hDEAD_BEEF;
        cyc();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("restart load_cnt", 64'(load_cnt), 64'd0);
        put_rows(0, 31);
        @(negedge clk);
        chk("31 rows loaded", 64'(loaded), 64'd0);
        cfg_valid = 1'b1;
        cfg_data  = 32'h8000_0000;
        cyc();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("32 rows loaded", 64'(loaded), 64'd1);
        out_ready = 1'b1;
        send_one("after restart", 32'h8000_0001, 32'h8000_0001);

        // Randomized traffic checked cycle by cycle against the model.
        do_load(2);
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            cfg_start = ($urandom_range(0, 127) == 0);
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_data  = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst = 1'b0;
        cyc();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
